// File: rtl/systolic_pkg.sv
// Shared types for the 2x2 systolic array result path: element widths,
// result-set layout, element ordering and drain FSM states.
package systolic_pkg;

    localparam int ACC_WIDTH = 9;

    typedef logic [ACC_WIDTH-1:0] acc_t;

    typedef struct packed {
        acc_t c00;
        acc_t c01;
        acc_t c10;
        acc_t c11;
    } result_set_t;

    typedef logic [1:0] elem_idx_t;

    localparam elem_idx_t IDX_C00 = 2'd0;
    localparam elem_idx_t IDX_C01 = 2'd1;
    localparam elem_idx_t IDX_C10 = 2'd2;
    localparam elem_idx_t IDX_C11 = 2'd3;

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

endpackage

// File: rtl/result_set_fifo.sv
// Whole-result-set FIFO: storage, wrapping pointers and occupancy level.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module result_set_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        level_d = level_q + LW'(push) - LW'(pop);
    end

    // When full, a push lands on the slot being popped in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);

endmodule

// File: rtl/systolic_result_drain.sv
// Captures 2x2 result sets and streams them element by element (c00, c01, c10, c11)
// over a valid/ready port; sets arriving into a full buffer are dropped and flagged.
module systolic_result_drain #(
    parameter int ACC_WIDTH = systolic_pkg::ACC_WIDTH,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    input  logic [ACC_WIDTH-1:0]       c00,
    input  logic [ACC_WIDTH-1:0]       c01,
    input  logic [ACC_WIDTH-1:0]       c10,
    input  logic [ACC_WIDTH-1:0]       c11,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [ACC_WIDTH-1:0]       m_data,
    output logic [1:0]                 m_idx,
    output logic                       m_last,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    input  logic                       clr_overflow
);
    import systolic_pkg::*;

    localparam int SET_W = 4 * ACC_WIDTH;

    logic [SET_W-1:0]     in_set;
    logic [SET_W-1:0]     head_set;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 handshake;
    logic                 last_handshake;
    logic                 push_accept;
    logic                 drop;
    state_t               state;
    elem_idx_t            idx_q, idx_d;
    logic                 overflow_q, overflow_d;
    logic [ACC_WIDTH-1:0] head_elem;

    assign in_set = {c00, c01, c10, c11};

    result_set_fifo #(
        .WIDTH(SET_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push_accept),
        .push_data(in_set),
        .pop      (last_handshake),
        .head_data(head_set),
        .level    (level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // State follows the registered level so m_valid rises the cycle after capture.
    always_comb begin
        state          = fifo_empty ? S_IDLE : S_STREAM;
        handshake      = (state == S_STREAM) && m_ready;
        last_handshake = handshake && (idx_q == IDX_C11);
        push_accept    = in_valid && (!fifo_full || last_handshake);
        drop           = in_valid && !push_accept;
    end

    always_comb begin
        head_elem = head_set[ACC_WIDTH-1:0];
        case (idx_q)
            IDX_C00: head_elem = head_set[4*ACC_WIDTH-1 -: ACC_WIDTH];
            IDX_C01: head_elem = head_set[3*ACC_WIDTH-1 -: ACC_WIDTH];
            IDX_C10: head_elem = head_set[2*ACC_WIDTH-1 -: ACC_WIDTH];
            default: head_elem = head_set[ACC_WIDTH-1:0];
        endcase
    end

    always_comb begin
        idx_d = handshake ? elem_idx_t'(idx_q + 2'd1) : idx_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q      <= IDX_C00;
            overflow_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    assign m_valid  = (state == S_STREAM);
    assign m_data   = m_valid ? head_elem : '0;
    assign m_idx    = idx_q;
    assign m_last   = m_valid && (idx_q == IDX_C11);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomized and directed scoreboard bench for systolic_result_drain; the model
// keeps the expected element stream as a plain queue of {data, index}.
module tb_systolic_result_drain;
    import systolic_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = ACC_WIDTH;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rstn;
    logic          in_valid;
    logic [W-1:0]  c00, c01, c10, c11;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [1:0]    m_idx;
    logic          m_last;
    logic [LW-1:0] level;
    logic          overflow;
    logic          clr_overflow;

    typedef struct {
        logic [W-1:0] data;
        int           idx;
    } exp_elem_t;

    exp_elem_t exp_q[$];
    logic      model_ovf;
    int        compared   = 0;
    int        mismatched = 0;
    int        model_sets;
    bit        model_last_hs;
    bit        model_accept;

    systolic_result_drain #(
        .ACC_WIDTH(W),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .c00         (c00),
        .c01         (c01),
        .c10         (c10),
        .c11         (c11),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_idx       (m_idx),
        .m_last      (m_last),
        .level       (level),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] c, input logic [W-1:0] d,
                                 input logic rdy, input logic clr);
        @(posedge clk);
        #1;
        in_valid     = v;
        c00          = a;
        c01          = b;
        c10          = c;
        c11          = d;
        m_ready      = rdy;
        clr_overflow = clr;
    endtask

    task automatic idleCycle(input logic rdy);
        applyStimulus(1'b0, '0, '0, '0, '0, rdy, 1'b0);
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            idleCycle(1'b1);
            n++;
        end
        compared++;
        if (exp_q.size() > 0) begin
            mismatched++;
            $display("[TB] FAIL drain_timeout: %0d elements left, expected 0", exp_q.size());
        end
        idleCycle(1'b1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_m_valid"}, m_valid, 0);
        checkOutput({tag, "_m_data"}, m_data, 0);
        checkOutput({tag, "_m_idx"}, m_idx, 0);
        checkOutput({tag, "_m_last"}, m_last, 0);
        checkOutput({tag, "_level"}, level, 0);
        checkOutput({tag, "_overflow"}, overflow, 0);
    endtask

    // Scoreboard: compare against the model's pre-edge state, then predict the coming edge.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            model_ovf = 1'b0;
        end else begin
            model_sets    = (exp_q.size() + 3) / 4;
            model_last_hs = m_ready && (exp_q.size() > 0) && (exp_q.size() % 4 == 1);
            model_accept  = in_valid && ((model_sets < DEPTH) || model_last_hs);
            checkOutput("m_valid", m_valid, (exp_q.size() > 0) ? 1 : 0);
            checkOutput("level", level, model_sets);
            checkOutput("overflow", overflow, model_ovf);
            if (exp_q.size() > 0) begin
                checkOutput("m_data", m_data, exp_q[0].data);
                checkOutput("m_idx", m_idx, exp_q[0].idx);
                checkOutput("m_last", m_last, (exp_q[0].idx == 3) ? 1 : 0);
                if (m_ready) begin
                    void'(exp_q.pop_front());
                end
            end
            if (model_accept) begin
                exp_q.push_back('{c00, 0});
                exp_q.push_back('{c01, 1});
                exp_q.push_back('{c10, 2});
                exp_q.push_back('{c11, 3});
            end
            if (in_valid && !model_accept) begin
                model_ovf = 1'b1;
            end else if (clr_overflow) begin
                model_ovf = 1'b0;
            end
        end
    end

    initial begin
        logic pattern [7];
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        rstn = 1'b0; in_valid = 1'b0; m_ready = 1'b0; clr_overflow = 1'b0;
        c00 = '0; c01 = '0; c10 = '0; c11 = '0;
        #2;
        checkResetOutputs("reset");
        idleCycle(1'b0);
        idleCycle(1'b0);
        rstn = 1'b1;

        $display("[TB] single set");
        applyStimulus(1'b1, 9'd5, 9'd9, 9'd12, 9'd20, 1'b1, 1'b0);
        drain(20);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 9'd5, 9'd9, 9'd12, 9'd20, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            idleCycle(pattern[i]);
        end
        idleCycle(1'b0);
        drain(20);

        $display("[TB] fill and overflow");
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, W'(k), W'(k + 1), W'(k + 2), W'(k + 3), 1'b0, 1'b0);
        end
        idleCycle(1'b0);
        idleCycle(1'b0);
        drain(40);
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        idleCycle(1'b0);

        $display("[TB] simultaneous write and last handshake");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, W'(20 + k), W'(40 + k), W'(60 + k), W'(80 + k), 1'b0, 1'b0);
        end
        idleCycle(1'b1);
        idleCycle(1'b1);
        idleCycle(1'b1);
        applyStimulus(1'b1, 9'd300, 9'd301, 9'd302, 9'd303, 1'b1, 1'b0);
        idleCycle(1'b0);
        drain(40);

        $display("[TB] back-to-back");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, W'(100 + k), W'(200 + k), W'(300 + k), W'(400 + k), 1'b1, 1'b0);
            idleCycle(1'b1);
            idleCycle(1'b1);
            idleCycle(1'b1);
        end
        drain(20);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 9'd11, 9'd22, 9'd33, 9'd44, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd55, 9'd66, 9'd77, 9'd88, 1'b0, 1'b0);
        idleCycle(1'b1);
        idleCycle(1'b1);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checkOutput("pre_reset_m_idx", m_idx, 2);
        rstn = 1'b0;
        #1;
        checkResetOutputs("midreset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        applyStimulus(1'b1, 9'd7, 9'd8, 9'd9, 9'd10, 1'b1, 1'b0);
        drain(20);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 2) == 0,
                          W'($urandom_range(0, 511)), W'($urandom_range(0, 511)),
                          W'($urandom_range(0, 511)), W'($urandom_range(0, 511)),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        drain(200);
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
        idleCycle(1'b1);
        idleCycle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Downstream consumer of the 2x2 systolic array. It captures each four-element result set `c00..c11` when the array pulses `out_valid`, and buffers whole sets in a small FIFO. It then streams the elements one per handshake over a valid/ready interface in the order c00, c01, c10, c11, tagged with element index and last flag. Sets arriving while the FIFO is full are dropped and flagged by a sticky overflow bit.

## Interface
- `ACC_WIDTH`, 9, width of each result element; matches the array accumulator width.
- `DEPTH`, 4, number of result sets buffered; power of two, ≥2.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  result-set strobe, driven by the array's `out_valid`; one set captured per high cycle.
- `c00`, `c01`, `c10`, `c11`  in  ACC_WIDTH each  result elements, sampled when `in_valid`=1.
- `m_valid`  out  1  output element valid.
- `m_ready`  in  1  consumer ready.
- `m_data`  out  ACC_WIDTH  current element.
- `m_idx`  out  2  element index: 0=c00, 1=c01, 2=c10, 3=c11.
- `m_last`  out  1  high when `m_idx`=3.
- `level`  out  $clog2(DEPTH+1)  number of result sets held, including a partially streamed set.
- `overflow`  out  1  sticky: a set was dropped.
- `clr_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- Storage: DEPTH entries of {c00, c01, c10, c11}, plus write pointer, read pointer and `level`.
- Write: when `in_valid`=1, the set is accepted if `level`<DEPTH, or if the last element of the head set (`m_valid & m_ready & m_last`) is handshaken in the same cycle. Otherwise the set is dropped: FIFO contents are unchanged and `overflow` is set.
- Read FSM:
  - IDLE (`level`==0): `m_valid`=0, element counter `idx`=0.
  - IDLE -> STREAM when `level` becomes nonzero.
  - In STREAM: `m_valid`=1, `m_data`=head[`idx`], `m_idx`=`idx`.
  - Each handshake (`m_valid & m_ready`) advances `idx` by 1.
  - On handshake at `idx`=3: `idx` wraps to 0, the read pointer advances, the entry is freed, and the FSM returns to IDLE if `level` becomes 0.
- `level` update each cycle: `level` + (write accepted) − (last-element handshake). A simultaneous accepted write and last-element handshake leaves `level` unchanged.
- Pointers wrap modulo DEPTH.
- `overflow`: set on any dropped set. `clr_overflow` clears it. If a drop and a clear occur in the same cycle, set wins.
- Data is passed through unmodified. No arithmetic; widths are preserved.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_idx`=0, `m_last`=0, `level`=0, `overflow`=0. Both pointers and `idx` are 0.
- Reset mid-stream discards all stored sets and any partially streamed set immediately (asynchronous).
- Latency: `in_valid` sampled at edge N into an empty FIFO gives `m_valid`=1 with c00 in the cycle after edge N. With `m_ready` held high, c11 is presented 3 cycles later.
- Throughput: 1 element per cycle, i.e. one set per 4 cycles. A back-to-back set follows c11 without a bubble.
- Stall: while `m_valid` & !`m_ready`, the outputs `m_data`, `m_idx` and `m_last` hold stable. `m_valid` never deasserts without a handshake.
- `m_valid`, `m_data`, `m_idx` and `m_last` are derived only from flops: the `level` register, the head entry and `idx`. There is no combinational path from `m_ready` or `in_valid`.

## Structure
- Package `systolic_pkg` holds:
  - `ACC_WIDTH` default.
  - `typedef logic [ACC_WIDTH-1:0] acc_t`.
  - `typedef struct packed {acc_t c00, c01, c10, c11;} result_set_t`.
  - `typedef logic [1:0] elem_idx_t`.
  - Element-order constants `IDX_C00`..`IDX_C11`.
  - Read FSM state enum `{S_IDLE, S_STREAM}`.
- Sub-module `result_set_fifo`: storage, pointers, `level`, full/empty, and a pop-enable input. The top level holds the write-accept logic, overflow logic, read FSM and element mux.

## Test plan
- Single set: `in_valid` once with c00..c11 = 5, 9, 12, 20, `m_ready`=1 -> outputs 5, 9, 12, 20 on 4 consecutive cycles. `m_idx` = 0..3, `m_last` only on 20. `level` goes 1 then 0 after the 4th handshake.
- Backpressure: same set, `m_ready` toggled 1, 0, 0, 1, 1, 0, 1 -> each element is held stable while stalled. Exactly 4 handshakes occur, in order.
- Fill and overflow (DEPTH=4): 5 strobes with `m_ready`=0, set k = {k, k+1, k+2, k+3} -> `level`=4 and `overflow`=1 after the 5th strobe. After releasing `m_ready`, sets 1..4 stream out and set 5 is absent. `clr_overflow` pulse -> `overflow`=0.
- Simultaneous: FIFO full, `m_ready`=1, `in_valid` on the cycle c11 of the head set handshakes -> set accepted, `level` stays 4, `overflow` stays 0.
- Back-to-back: strobes every 4 cycles with `m_ready`=1 -> continuous `m_valid`, `level` ≤1, no bubbles.
- Reset mid-stream: assert `rstn`=0 while `m_idx`=2 with 2 sets held -> all outputs 0 immediately. After release, a new set streams from c00.
